load_store_unit: RTL

Sequences RV32I loads and stores from the execute stage onto the word-wide, word-indexed `data_memory` array. The array has a combinational read and a clocked write. This block handles:
- sub-word extraction with sign or zero extension;
- read-modify-write for byte and halfword stores;
- alignment and range checking.

It sits between the core's memory stage and `data_memory`, and it is the only master of that array.

---
 rtl/load_store_unit.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// RV32I load/store sequencer in front of a word-indexed data_memory array.
// Handles sub-word extraction, read-modify-write for sb/sh, and fault detection.
module load_store_unit #(
    parameter int unsigned DEPTH_WORDS = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {StIdle, StAccess, StWrite, StResp} state_t;

    state_t      state_q;
    logic        we_q;
    logic [2:0]  funct3_q;
    logic [1:0]  addr_lo_q;
    logic [15:0] wdata_q;

    logic        req_illegal;
    logic        req_misaligned;
    logic        req_out_of_range;
    logic        req_fault;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_ext;
    logic [31:0] merged;

    assign req_ready = (state_q == StIdle);

    // Fault decode on the raw request, evaluated at acceptance.
    always_comb begin
        req_illegal    = 1'b0;
        req_misaligned = 1'b0;
        if (req_we) begin
            req_illegal = (req_funct3 != 3'b000) && (req_funct3 != 3'b001) &&
                          (req_funct3 != 3'b010);
        end else begin
            req_illegal = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                          (req_funct3 == 3'b111);
        end
        case (req_funct3[1:0])
            2'b01:   req_misaligned = req_addr[0];
            2'b10:   req_misaligned = |req_addr[1:0];
            default: req_misaligned = 1'b0;
        endcase
        req_out_of_range = ({2'b00, req_addr[31:2]} >= DEPTH_WORDS);
        req_fault        = req_illegal || req_misaligned || req_out_of_range;
    end

    // Little-endian lane selection and extension for loads.
    always_comb begin
        case (addr_lo_q)
            2'd0:    rd_byte = mem_rdata[7:0];
            2'd1:    rd_byte = mem_rdata[15:8];
            2'd2:    rd_byte = mem_rdata[23:16];
            default: rd_byte = mem_rdata[31:24];
        endcase
        rd_half = addr_lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (funct3_q[1:0])
            2'b00:   load_ext = {{24{~funct3_q[2] & rd_byte[7]}}, rd_byte};
            2'b01:   load_ext = {{16{~funct3_q[2] & rd_half[15]}}, rd_half};
            default: load_ext = mem_rdata;
        endcase
    end

    // Merge store data into the current word for sb/sh.
    always_comb begin
        merged = mem_rdata;
        if (funct3_q[1:0] == 2'b00) begin
            case (addr_lo_q)
                2'd0:    merged[7:0]   = wdata_q[7:0];
                2'd1:    merged[15:8]  = wdata_q[7:0];
                2'd2:    merged[23:16] = wdata_q[7:0];
                default: merged[31:24] = wdata_q[7:0];
            endcase
        end else if (addr_lo_q[1]) begin
            merged[31:16] = wdata_q;
        end else begin
            merged[15:0] = wdata_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            we_q       <= 1'b0;
            funct3_q   <= 3'b000;
            addr_lo_q  <= 2'b00;
            wdata_q    <= 16'h0000;
            resp_valid <= 1'b0;
            resp_rdata <= 32'h0;
            resp_fault <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= 32'h0;
            mem_wdata  <= 32'h0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        we_q      <= req_we;
                        funct3_q  <= req_funct3;
                        addr_lo_q <= req_addr[1:0];
                        wdata_q   <= req_wdata[15:0];
                        if (req_fault) begin
                            state_q    <= StResp;
                            resp_valid <= 1'b1;
                            resp_fault <= 1'b1;
                            resp_rdata <= 32'h0;
                        end else begin
                            state_q  <= StAccess;
                            mem_addr <= {2'b00, req_addr[31:2]};
                            // sw commits straight out of ACCESS, so drive it now.
                            if (req_we && (req_funct3 == 3'b010)) begin
                                mem_we    <= 1'b1;
                                mem_wdata <= req_wdata;
                            end
                        end
                    end
                end
                StAccess: begin
                    if (we_q && (funct3_q != 3'b010)) begin
                        state_q   <= StWrite;
                        mem_we    <= 1'b1;
                        mem_wdata <= merged;
                    end else begin
                        state_q    <= StResp;
                        mem_we     <= 1'b0;
                        mem_addr   <= 32'h0;
                        mem_wdata  <= 32'h0;
                        resp_valid <= 1'b1;
                        resp_fault <= 1'b0;
                        resp_rdata <= we_q ? 32'h0 : load_ext;
                    end
                end
                StWrite: begin
                    state_q    <= StResp;
                    mem_we     <= 1'b0;
                    mem_addr   <= 32'h0;
                    mem_wdata  <= 32'h0;
                    resp_valid <= 1'b1;
                    resp_fault <= 1'b0;
                    resp_rdata <= 32'h0;
                end
                StResp: begin
                    if (resp_ready) begin
                        state_q    <= StIdle;
                        resp_valid <= 1'b0;
                        resp_fault <= 1'b0;
                        resp_rdata <= 32'h0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
